// File: rtl/kfpga_config_pkg.sv
// Shared definitions for routing-block configuration loaders: loader state
// encoding, word-count helpers and the switch box config vector layout.
package kfpga_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } cfg_state_e;

  // Switch box layout for the 10-track, 4-LE, 6-input tile:
  // 40 track muxes of 3 bits, followed by 24 LE input muxes of 6 bits.
  localparam int SB_CONFIG_WIDTH     = 264;
  localparam int SB_TRACK_MUX_BITS   = 3;
  localparam int SB_NUM_TRACK_MUX    = 40;
  localparam int SB_TRACK_MUX_OFFSET = 0;
  localparam int SB_LE_MUX_BITS      = 6;
  localparam int SB_NUM_LE_MUX       = 24;
  localparam int SB_LE_MUX_OFFSET    = SB_TRACK_MUX_OFFSET + SB_TRACK_MUX_BITS * SB_NUM_TRACK_MUX;

  function automatic int cfg_num_words(input int width, input int word_width);
    return (width + word_width - 1) / word_width;
  endfunction

  function automatic int cfg_count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/config_word_counter.sv
// Word counter for configuration loaders: synchronous clear, count enable,
// wraps to zero after COUNT_MAX and flags the terminal value.
module config_word_counter
  import kfpga_config_pkg::*;
#(
  parameter int COUNT_MAX = 32,
  parameter int WIDTH     = cfg_count_width(COUNT_MAX + 1)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT_MAX);

  logic [WIDTH-1:0] count_q, count_d;

  assign terminal = (count_q == LAST);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = terminal ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Switch box configuration writer: collects a word-serial bitstream into a
// shadow register, verifies an XOR checksum, then commits it to config_out.
module config_loader
  import kfpga_config_pkg::*;
#(
  parameter int CONFIG_WIDTH = SB_CONFIG_WIDTH,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_loaded,
  output logic                    busy,
  output logic                    error
);

  localparam int NUM_WORDS = cfg_num_words(CONFIG_WIDTH, WORD_WIDTH);
  localparam int CNT_W     = cfg_count_width(NUM_WORDS);
  localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;

  // Stream handshake: a word transfers on any rising edge where
  // data_in_valid and data_in_ready are both high; ready depends only on state.
  cfg_state_e              state_q, state_d;
  logic [WORD_WIDTH-1:0]   acc_q, acc_d;
  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic                    loaded_q, loaded_d;
  logic                    error_q, error_d;

  logic [SHADOW_W-1:0]     shadow_wide;
  logic [CNT_W-1:0]        word_count;
  int                      word_base;
  logic                    last_word;
  logic                    handshake;
  logic                    count_en;

  assign data_in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign handshake     = data_in_valid && data_in_ready;
  assign count_en      = handshake && (state_q == ST_LOAD) && !start;
  assign word_base     = int'(word_count) * WORD_WIDTH;

  config_word_counter #(
    .COUNT_MAX (NUM_WORDS - 1),
    .WIDTH     (CNT_W)
  ) u_word_counter (
    .clock    (clock),
    .nreset   (nreset),
    .clear    (start),
    .enable   (count_en),
    .count    (word_count),
    .terminal (last_word)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    loaded_d = loaded_q;
    error_d  = error_q;

    // Widened view so the final word can be written whole; bits past
    // CONFIG_WIDTH fall away when narrowed back.
    shadow_wide = '0;
    shadow_wide[CONFIG_WIDTH-1:0] = shadow_q;
    shadow_wide[word_base +: WORD_WIDTH] = data_in;

    if (start) begin
      state_d = ST_LOAD;
      acc_d   = '0;
      error_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (handshake) begin
            shadow_d = shadow_wide[CONFIG_WIDTH-1:0];
            acc_d    = acc_q ^ data_in;
            if (last_word) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (handshake) begin
            if (data_in == acc_q) begin
              state_d = ST_COMMIT;
            end else begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_COMMIT: begin
          cfg_d    = shadow_q;
          loaded_d = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      loaded_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      loaded_q <= loaded_d;
      error_q  <= error_d;
    end
  end

  assign config_out    = cfg_q;
  assign config_loaded = loaded_q;
  assign error         = error_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
